bias_bank_add: RTL

- Parametrised successor to the per-layer constant bias blocks: one runtime-loadable bias bank covering N_GROUPS output-channel groups of N_adder_tree lanes.
- Adds the current group's biases to adder-tree accumulator outputs, with signed saturation and optional ReLU.
- Sits between the adder tree and the activation/requant path.
- Uses a 2-stage valid/ready pipeline and an auto-advancing group pointer.

---
 rtl/bias_pkg.sv | 36 +++
 rtl/sat_add_relu_lane.sv | 42 ++++
 rtl/bias_bank_add.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/bias_pkg.sv
`default_nettype none
// ============================================================================
// Package     : bias_pkg
// Description : Shared widths, saturation bounds and lane helpers for the
//               bias bank datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package bias_pkg;

    localparam int DATA_W_DFLT = 18;
    localparam int LANES_DFLT  = 16;

    localparam logic [DATA_W_DFLT-1:0] SAT_MAX = {1'b0, {(DATA_W_DFLT-1){1'b1}}};
    localparam logic [DATA_W_DFLT-1:0] SAT_MIN = {1'b1, {(DATA_W_DFLT-1){1'b0}}};

    function automatic logic [DATA_W_DFLT-1:0] lane_slice(
        input logic [LANES_DFLT*DATA_W_DFLT-1:0] vec,
        input int                                i
    );
        return vec[DATA_W_DFLT*i +: DATA_W_DFLT];
    endfunction

    // Returns {flag, result}; overflow shows up as disagreeing top two sum bits.
    function automatic logic [DATA_W_DFLT:0] sat_add(
        input logic [DATA_W_DFLT-1:0] a,
        input logic [DATA_W_DFLT-1:0] b
    );
        logic [DATA_W_DFLT:0] s;
        s = {a[DATA_W_DFLT-1], a} + {b[DATA_W_DFLT-1], b};
        if (s[DATA_W_DFLT] != s[DATA_W_DFLT-1])
            return {1'b1, (s[DATA_W_DFLT] ? SAT_MIN : SAT_MAX)};
        return {1'b0, s[DATA_W_DFLT-1:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_add_relu_lane.sv
`default_nettype none
// ============================================================================
// Module      : sat_add_relu_lane
// Description : One lane of signed saturating accumulator+bias add with
//               optional negative clamp to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_add_relu_lane
    import bias_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT
)(
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] bias,
    input  logic              relu_en,
    output logic [DATA_W-1:0] result,
    output logic              sat
);

    logic [DATA_W-1:0] w_clip;

    generate
        if (DATA_W == DATA_W_DFLT) begin : g_pkg_sat
            assign {sat, w_clip} = sat_add(acc, bias);
        end else begin : g_gen_sat
            localparam logic [DATA_W-1:0] c_max = {1'b0, {(DATA_W-1){1'b1}}};
            localparam logic [DATA_W-1:0] c_min = {1'b1, {(DATA_W-1){1'b0}}};

            logic [DATA_W:0] w_sum;

            assign w_sum  = {acc[DATA_W-1], acc} + {bias[DATA_W-1], bias};
            assign sat    = w_sum[DATA_W] ^ w_sum[DATA_W-1];
            assign w_clip = !sat           ? w_sum[DATA_W-1:0] :
                            w_sum[DATA_W]  ? c_min : c_max;
        end
    endgenerate

    // Saturation is resolved first so the flag survives a ReLU zeroing.
    assign result = (relu_en && w_clip[DATA_W-1]) ? '0 : w_clip;

endmodule
`default_nettype wire

// File: rtl/bias_bank_add.sv
`default_nettype none
// ============================================================================
// Module      : bias_bank_add
// Description : Runtime-loadable per-group bias bank added to adder-tree
//               lanes through a 2-stage valid/ready pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module bias_bank_add
    import bias_pkg::*;
#(
    parameter  int N_adder_tree = 16,
    parameter  int DATA_W       = DATA_W_DFLT,
    parameter  int N_GROUPS     = 8,
    localparam int AW           = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
    localparam int VW           = N_adder_tree * DATA_W
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [VW-1:0] cfg_data,
    output logic          cfg_err,
    input  logic          start,
    input  logic          relu_en,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [VW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [VW-1:0] out_data,
    output logic          out_last,
    output logic          out_sat,
    output logic [AW-1:0] grp_ptr
);

    localparam logic [AW:0]   c_n_groups = (AW+1)'(N_GROUPS);
    localparam logic [AW-1:0] c_last_grp = AW'(N_GROUPS - 1);
    localparam logic [AW-1:0] c_one      = AW'(1);

    logic [VW-1:0]           r_bank [N_GROUPS];
    logic [AW-1:0]           r_grp_ptr;
    logic                    r_cfg_err;

    logic                    r_s1_valid;
    logic [VW-1:0]           r_s1_acc;
    logic [VW-1:0]           r_s1_bias;
    logic                    r_s1_last;
    logic                    r_s1_relu;

    logic                    r_s2_valid;
    logic [VW-1:0]           r_out_data;
    logic                    r_out_last;
    logic                    r_out_sat;

    logic                    w_s1_move;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_s2_load;
    logic                    w_cfg_idle;
    logic                    w_addr_ok;
    logic                    w_cfg_ok;
    logic [VW-1:0]           w_lane_res;
    logic [N_adder_tree-1:0] w_lane_sat;

    assign w_s1_move  = !r_s2_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s1_move;
    assign w_accept   = in_valid && w_in_ready;
    assign w_s2_load  = r_s1_valid && w_s1_move;

    // Writes are only safe with nothing in flight and nothing being offered.
    assign w_cfg_idle = !r_s1_valid && !r_s2_valid && !in_valid;
    assign w_addr_ok  = ({1'b0, cfg_addr} < c_n_groups);
    assign w_cfg_ok   = cfg_we && w_cfg_idle && w_addr_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < N_GROUPS; g++)
                r_bank[g] <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            if (w_cfg_ok)
                r_bank[cfg_addr] <= cfg_data;
            r_cfg_err <= cfg_we && !(w_cfg_idle && w_addr_ok);
        end
    end

    // Start has priority over an end-of-group advance in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grp_ptr <= '0;
        end else if (start) begin
            r_grp_ptr <= '0;
        end else if (w_accept && in_last) begin
            r_grp_ptr <= (r_grp_ptr == c_last_grp) ? '0 : r_grp_ptr + c_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_acc   <= '0;
            r_s1_bias  <= '0;
            r_s1_last  <= 1'b0;
            r_s1_relu  <= 1'b0;
        end else if (w_in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_acc  <= in_data;
                r_s1_bias <= r_bank[r_grp_ptr];
                r_s1_last <= in_last;
                r_s1_relu <= relu_en;
            end
        end
    end

    generate
        for (genvar l = 0; l < N_adder_tree; l++) begin : g_lane
            sat_add_relu_lane #(
                .DATA_W (DATA_W)
            ) u_lane (
                .acc     (r_s1_acc  [DATA_W*l +: DATA_W]),
                .bias    (r_s1_bias [DATA_W*l +: DATA_W]),
                .relu_en (r_s1_relu),
                .result  (w_lane_res[DATA_W*l +: DATA_W]),
                .sat     (w_lane_sat[l])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
            r_out_sat  <= 1'b0;
        end else begin
            if (w_s1_move)
                r_s2_valid <= r_s1_valid;
            if (w_s2_load) begin
                r_out_data <= w_lane_res;
                r_out_last <= r_s1_last;
                r_out_sat  <= |w_lane_sat;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_s2_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_sat   = r_out_sat;
    assign grp_ptr   = r_grp_ptr;
    assign cfg_err   = r_cfg_err;

endmodule
`default_nettype wire
